counter_cmd_decoder: RTL and testbench
======================================

# counter_cmd_decoder

- Front-end stage that drives the 4-bit up/down counter from raw board inputs.
- Synchronises and debounces three push buttons (up, down, load) and applies auto-repeat to up/down.
- Emits single-cycle command pulses on the counter's control inputs: `enable`, `up_down`, `set`, `set_value`.
- Connects port-for-port to the counter; no glue logic.

## Interface
- `DEBOUNCE_CYCLES`, 500000 — consecutive stable synced samples needed to accept a level change (≥2).
- `REPEAT_DELAY`, 25000000 — cycles a debounced up/down press is held before the first repeat pulse; 0 disables repeat.
- `REPEAT_PERIOD`, 5000000 — cycles between subsequent repeat pulses (≥1).
- `clk` in 1 — single clock, all logic on rising edge.
- `reset_n` in 1 — asynchronous, active-low reset; deassertion is synchronous to `clk` externally.
- `btn_up` in 1 — raw asynchronous button, active-high.
- `btn_down` in 1 — raw asynchronous button, active-high.
- `btn_load` in 1 — raw asynchronous button, active-high.
- `sw` in 4 — raw asynchronous switches, the load value.
- `enable` out 1 — one-cycle count pulse.
- `up_down` out 1 — direction: 1 = up, 0 = down; held between pulses.
- `set` out 1 — one-cycle load pulse.
- `set_value` out 4 — value to load; stable while `set` is high and held afterwards.

## Operation
- **Synchronisation**
  - Every button and `sw` bit passes through a 2-flop synchroniser.
  - `sw` is synchronised but not debounced.
- **Per-button FSM** (states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT):
  - IDLE → PRESS_WAIT when the synced input is 1; the stability counter clears.
  - PRESS_WAIT → PRESSED when the counter reaches DEBOUNCE_CYCLES−1 with the input still 1. This transition raises `press` for 1 cycle.
  - PRESS_WAIT → IDLE when the input returns to 0 before that point. No pulse.
  - PRESSED → RELEASE_WAIT when the input is 0.
  - RELEASE_WAIT → IDLE after DEBOUNCE_CYCLES stable 0 samples.
  - RELEASE_WAIT → PRESSED when the input returns to 1. No new `press`; the repeat timer is not reset.
- **Repeat**
  - Applies to up/down only, in PRESSED or RELEASE_WAIT.
  - A hold timer counts from PRESSED entry. It raises `repeat` when the timer equals REPEAT_DELAY, and every REPEAT_PERIOD cycles after that.
  - The timer saturates. It clears in IDLE.
- **Arbitration**, evaluated each cycle on the `press`/`repeat` events:
  - Load event → `set`=1, `enable`=0. Up/down events that cycle are dropped.
  - Otherwise, an up event alone → `enable`=1, `up_down`=1.
  - A down event alone → `enable`=1, `up_down`=0.
  - Up and down events in the same cycle → no output pulse, `up_down` unchanged.
- **Output registers**
  - `set_value` is registered from synced `sw` in the same cycle `set` asserts. It holds otherwise.
  - `set` and `enable` are never both 1.

## Timing
- Reset values: `enable`=0, `set`=0, `up_down`=1, `set_value`=0. All FSMs IDLE; all timers and synchronisers 0.
- Press latency: a raw 0→1 that is stable from edge E gives `enable`/`set` high in cycle E+DEBOUNCE_CYCLES+2, for exactly 1 cycle.
- Glitches shorter than DEBOUNCE_CYCLES synced cycles produce no pulse.
- Held up/down: the first repeat pulse comes REPEAT_DELAY cycles after the press pulse, then one every REPEAT_PERIOD cycles until release is accepted.
- `reset_n` low mid-press: outputs go to reset values immediately and asynchronously. After release, a still-held button is treated as a new press and goes through a full debounce.
- A button held through reset gives exactly one press pulse after reset.

## Structure
- Shared package `counter_pkg`:
  - `btn_state_t` enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT).
  - Constant `COUNT_W` = 4.
  - Direction constants `DIR_UP` = 1, `DIR_DOWN` = 0.
- Sub-module `btn_debounce`: synchroniser, FSM and optional repeat timer. It exposes `press`, `repeat`, `level`.
  - Instantiated 3 times; load has repeat disabled (REPEAT_DELAY = 0).
- Top level holds the `sw` synchroniser, arbitration and output registers.
- Expected size: ~200 lines total.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_PERIOD=8.
- Reset: hold `reset_n`=0 with all buttons toggling → `enable`=0, `set`=0, `up_down`=1, `set_value`=0 throughout.
- Clean up press: raw `btn_up` rises at edge 10 and is held 10 cycles → one pulse, `enable`=1 with `up_down`=1 at cycle 16.
- Bounce: raw `btn_down` pattern 1,0,1,1,0,1×6 → exactly one `enable` pulse with `up_down`=0, 4+2 cycles after the final stable rise.
- Auto-repeat: hold `btn_up` for 60 cycles after acceptance.
  - `enable` pulses at cycles P, P+16, P+24, P+32, P+40, P+48, P+56.
  - None after release is accepted.
- Load priority: `sw`=4'b1010 with `btn_load` and `btn_up` pressed together → `set`=1 and `set_value`=4'b1010 for 1 cycle, `enable`=0.
- Conflict and async reset:
  - Up and down accepted in the same cycle → no pulse, `up_down` unchanged.
  - `reset_n` low mid-PRESS_WAIT → no pulse; after release with the button held, one pulse 6 cycles later.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the counter front-end and its button
// conditioning logic.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  localparam int unsigned COUNT_W = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-flop synchroniser, debounce FSM and optional hold-to-repeat
// timer. press_c/repeat_c are single-cycle events aligned to the FSM update.
module btn_debounce
  import counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press_c,
  output logic repeat_c,
  output logic level
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
  localparam int unsigned PER_W  = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(REPEAT_DELAY);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(REPEAT_PERIOD - 1);
  localparam bit                REPEAT_EN = (REPEAT_DELAY != 0);

  logic              sync_q1, sync_q2;
  btn_state_t        state_q, state_d;
  logic [DB_W-1:0]   cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q;
  logic [PER_W-1:0]  per_q;
  logic              release_c;
  logic              active;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Press and release both need the new level held for DB_LAST+2 synced samples.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_c   = 1'b0;
    release_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync_q2) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_q2) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          press_c = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      PRESSED: begin
        if (!sync_q2) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync_q2) begin
          state_d = PRESSED;
        end else if (cnt_q == DB_LAST) begin
          state_d   = IDLE;
          release_c = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign active = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  assign level  = active;

  // hold_q saturates at the initial delay; per_q then paces the repeats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      per_q  <= '0;
    end else if (press_c) begin
      hold_q <= HOLD_W'(1);
      per_q  <= '0;
    end else if (!active || release_c) begin
      hold_q <= '0;
      per_q  <= '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_q <= hold_q + HOLD_W'(1);
    end else begin
      per_q <= (per_q == PER_LAST) ? '0 : per_q + PER_W'(1);
    end
  end

  assign repeat_c = REPEAT_EN && active && !release_c &&
                    (hold_q == HOLD_MAX) && (per_q == '0);

endmodule

// File: rtl/counter_cmd_decoder.sv
// Turns raw up/down/load buttons and load switches into single-cycle command
// pulses for the 4-bit up/down counter.
module counter_cmd_decoder
  import counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_load,
  input  logic [COUNT_W-1:0] sw,
  output logic               enable,
  output logic               up_down,
  output logic               set,
  output logic [COUNT_W-1:0] set_value
);

  logic               up_press_c, up_rpt_c, up_level;
  logic               dn_press_c, dn_rpt_c, dn_level;
  logic               ld_press_c, ld_rpt_c, ld_level;
  logic               up_ev_c, dn_ev_c, ld_ev_c;
  logic [COUNT_W-1:0] sw_q1, sw_q2;
  logic               unused_levels;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_up (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_up),
    .press_c (up_press_c),
    .repeat_c(up_rpt_c),
    .level   (up_level)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_down (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_down),
    .press_c (dn_press_c),
    .repeat_c(dn_rpt_c),
    .level   (dn_level)
  );

  // Load never auto-repeats.
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (0),
    .REPEAT_PERIOD  (1)
  ) u_load (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_load),
    .press_c (ld_press_c),
    .repeat_c(ld_rpt_c),
    .level   (ld_level)
  );

  assign unused_levels = ^{up_level, dn_level, ld_level, ld_rpt_c};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_q1 <= '0;
      sw_q2 <= '0;
    end else begin
      sw_q1 <= sw;
      sw_q2 <= sw_q1;
    end
  end

  assign up_ev_c = up_press_c | up_rpt_c;
  assign dn_ev_c = dn_press_c | dn_rpt_c;
  assign ld_ev_c = ld_press_c;

  // Load wins; simultaneous up and down cancel each other.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable    <= 1'b0;
      set       <= 1'b0;
      up_down   <= DIR_UP;
      set_value <= '0;
    end else begin
      set    <= ld_ev_c;
      enable <= !ld_ev_c && (up_ev_c ^ dn_ev_c);
      if (ld_ev_c) begin
        set_value <= sw_q2;
      end else if (up_ev_c && !dn_ev_c) begin
        up_down <= DIR_UP;
      end else if (dn_ev_c && !up_ev_c) begin
        up_down <= DIR_DOWN;
      end
    end
  end

endmodule

// File: tb/tb_counter_cmd_decoder.sv
// Directed scenarios plus random button traffic, checked every cycle against a
// run-length / elapsed-time reference model of the command decoder.
module tb_counter_cmd_decoder;

  localparam int unsigned D  = 4;
  localparam int unsigned RD = 16;
  localparam int unsigned RP = 8;

  logic       clk;
  logic       reset_n;
  logic       btn_up, btn_down, btn_load;
  logic [3:0] sw;
  logic       enable, up_down, set;
  logic [3:0] set_value;

  counter_cmd_decoder #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_load (btn_load),
    .sw       (sw),
    .enable   (enable),
    .up_down  (up_down),
    .set      (set),
    .set_value(set_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: index 0 = up, 1 = down, 2 = load.
  int unsigned run1 [3];
  int unsigned run0 [3];
  int unsigned held [3];
  bit          lvl  [3];
  bit          rs1  [3];
  bit          rs2  [3];
  logic [3:0]  sw1, sw2;
  bit          m_enable, m_set, m_up_down;
  logic [3:0]  m_set_value;

  int          checks = 0;
  int          errors = 0;
  int          step_no = 0;
  int          en_q [$];
  int          set_q [$];
  logic [3:0]  last_sv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      run1[i] = 0; run0[i] = 0; held[i] = 0; lvl[i] = 0; rs1[i] = 0; rs2[i] = 0;
    end
    sw1 = '0; sw2 = '0;
    m_enable = 0; m_set = 0; m_up_down = 1; m_set_value = '0;
  endtask

  // A level is accepted once D+1 consecutive synced samples agree; repeats
  // fire RD cycles after acceptance and every RP cycles after that.
  task automatic model_tick();
    bit raw [3];
    bit ev  [3];
    bit pr  [3];
    bit s;
    raw = '{btn_up, btn_down, btn_load};
    for (int i = 0; i < 3; i++) begin
      s = rs2[i];
      ev[i] = 0;
      pr[i] = 0;
      if (s) begin run1[i]++; run0[i] = 0; end
      else begin run0[i]++; run1[i] = 0; end
      if (!lvl[i]) begin
        if (run1[i] == D + 1) begin lvl[i] = 1; held[i] = 0; pr[i] = 1; end
      end else if (run0[i] == D + 1) begin
        lvl[i] = 0;
      end else begin
        held[i]++;
        if (i != 2 && (held[i] == RD || (held[i] > RD && (held[i] - RD) % RP == 0)))
          ev[i] = 1;
      end
      ev[i] = ev[i] | pr[i];
      rs2[i] = rs1[i];
      rs1[i] = raw[i];
    end
    m_set    = pr[2];
    m_enable = !pr[2] && (ev[0] != ev[1]);
    if (pr[2]) m_set_value = sw2;
    else if (ev[0] && !ev[1]) m_up_down = 1;
    else if (ev[1] && !ev[0]) m_up_down = 0;
    sw2 = sw1;
    sw1 = sw;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_tick();
    else model_reset();
    #1;
    step_no++;
    check("enable", 32'(enable), 32'(m_enable));
    check("set", 32'(set), 32'(m_set));
    check("up_down", 32'(up_down), 32'(m_up_down));
    check("set_value", 32'(set_value), 32'(m_set_value));
    if (enable) en_q.push_back(step_no);
    if (set) begin set_q.push_back(step_no); last_sv = set_value; end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int  base;
  int  p;
  bit  found;
  int  bounce [11] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1};
  int  rep_off [7] = '{0, 16, 24, 32, 40, 48, 56};

  initial begin
    reset_n = 1; btn_up = 0; btn_down = 0; btn_load = 0; sw = '0; last_sv = '0;
    model_reset();
    #2 reset_n = 0;

    // Reset held while buttons chatter.
    for (int i = 0; i < 8; i++) begin
      btn_up = 1'($urandom); btn_down = 1'($urandom); btn_load = 1'($urandom);
      sw = 4'($urandom);
      step();
      check("rst_ctrl", 32'({enable, set, up_down}), 32'd1);
      check("rst_set_value", 32'(set_value), 32'd0);
    end
    btn_up = 0; btn_down = 0; btn_load = 0; sw = '0;
    reset_n = 1;
    idle(10);

    // Clean up press.
    en_q.delete();
    btn_up = 1; base = step_no;
    idle(10);
    btn_up = 0;
    idle(20);
    check("clean_count", 32'(en_q.size()), 32'd1);
    if (en_q.size() > 0) check("clean_latency", 32'(en_q[0] - base), 32'd7);
    check("clean_dir", 32'(up_down), 32'd1);

    // Bouncy down press.
    en_q.delete();
    base = step_no;
    for (int i = 0; i < 11; i++) begin
      btn_down = 1'(bounce[i]);
      step();
    end
    btn_down = 0;
    idle(20);
    check("bounce_count", 32'(en_q.size()), 32'd1);
    if (en_q.size() > 0) check("bounce_latency", 32'(en_q[0] - base), 32'd12);
    check("bounce_dir", 32'(up_down), 32'd0);

    // Up and down accepted together cancel.
    en_q.delete();
    btn_up = 1; btn_down = 1;
    idle(10);
    btn_up = 0; btn_down = 0;
    idle(20);
    check("conflict_count", 32'(en_q.size()), 32'd0);
    check("conflict_dir", 32'(up_down), 32'd0);

    // Auto-repeat while held.
    en_q.delete();
    btn_up = 1; found = 0; p = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (enable) begin found = 1; p = step_no; end
    end
    check("repeat_first_seen", 32'(found), 32'd1);
    idle(57);
    btn_up = 0;
    idle(20);
    check("repeat_count", 32'(en_q.size()), 32'd7);
    for (int i = 0; i < 7 && i < en_q.size(); i++)
      check("repeat_offset", 32'(en_q[i] - p), 32'(rep_off[i]));

    // Load beats a simultaneous up press.
    en_q.delete(); set_q.delete();
    sw = 4'b1010;
    idle(4);
    btn_load = 1; btn_up = 1; base = step_no;
    idle(10);
    btn_load = 0; btn_up = 0;
    idle(20);
    check("load_set_count", 32'(set_q.size()), 32'd1);
    if (set_q.size() > 0) check("load_latency", 32'(set_q[0] - base), 32'd7);
    check("load_value", 32'(last_sv), 32'd10);
    check("load_enable_count", 32'(en_q.size()), 32'd0);

    // Reset mid-debounce with the button still held.
    en_q.delete();
    btn_up = 1;
    idle(4);
    reset_n = 0;
    model_reset();
    #1;
    check("async_rst_ctrl", 32'({enable, set, up_down}), 32'd1);
    check("async_rst_value", 32'(set_value), 32'd0);
    idle(3);
    reset_n = 1;
    base = step_no;
    idle(15);
    btn_up = 0;
    idle(20);
    check("async_count", 32'(en_q.size()), 32'd1);
    if (en_q.size() > 0) check("async_latency", 32'(en_q[0] - base), 32'd7);

    // Random traffic with a reset pulse in the middle.
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(7, 0) == 0) btn_up = ~btn_up;
      if ($urandom_range(7, 0) == 0) btn_down = ~btn_down;
      if ($urandom_range(9, 0) == 0) btn_load = ~btn_load;
      sw = 4'($urandom);
      if (i == 600) reset_n = 0;
      if (i == 603) reset_n = 1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
